// File: rtl/edc_pkg.sv
// Shared SEC-DED definitions: H-matrix column generator and check-bit encoder.
// Latency: n/a (elaboration-time and combinational helper functions only).
// Backpressure: n/a.
package edc_pkg;

    localparam int EDC_MIN_WEIGHT = 3;
    localparam int EDC_MAX_ECC    = 16;
    localparam int EDC_MAX_DATA   = 64;

    typedef logic [EDC_MAX_ECC-1:0]  edc_col_t;
    typedef logic [EDC_MAX_DATA-1:0] edc_data_t;

    function automatic int edc_popcount(input edc_col_t v);
        int n;
        n = 0;
        for (int b = 0; b < EDC_MAX_ECC; b++) begin
            n += int'(v[b]);
        end
        return n;
    endfunction

    // Data columns are the odd-weight codes of weight >= 3; weight 1 is
    // reserved for the check-bit unit vectors.
    function automatic bit edc_is_data_col(input edc_col_t v);
        int w;
        w = edc_popcount(v);
        return (w >= EDC_MIN_WEIGHT) && ((w % 2) == 1);
    endfunction

    function automatic int edc_num_columns(input int ecc_width);
        int n;
        n = 0;
        for (int v = 1; v < (1 << ecc_width); v++) begin
            if (edc_is_data_col(edc_col_t'(v))) begin
                n++;
            end
        end
        return n;
    endfunction

    // index-th data column, counting qualifying codes in ascending order.
    function automatic edc_col_t edc_h_column(input int index, input int ecc_width);
        int       seen;
        edc_col_t col;
        seen = 0;
        col  = '0;
        for (int v = 1; v < (1 << ecc_width); v++) begin
            if (edc_is_data_col(edc_col_t'(v))) begin
                if (seen == index) begin
                    col = edc_col_t'(v);
                end
                seen++;
            end
        end
        return col;
    endfunction

    function automatic edc_col_t edc_gen_ecc(input edc_data_t data, input int data_width,
                                             input int ecc_width);
        edc_col_t acc;
        acc = '0;
        for (int j = 0; j < data_width; j++) begin
            if (data[j]) begin
                acc ^= edc_h_column(j, ecc_width);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/edc_syndrome_gen.sv
// Check-bit generator and syndrome former (gen_ecc = XOR of set-bit columns).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; ports: i_data/i_ecc in, o_gen_ecc/o_syndrome out.
import edc_pkg::*;

module edc_syndrome_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ECC_WIDTH-1:0]  i_ecc,
    output logic [ECC_WIDTH-1:0]  o_gen_ecc,
    output logic [ECC_WIDTH-1:0]  o_syndrome
);

    logic [ECC_WIDTH-1:0] col_term [DATA_WIDTH];

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_col
        localparam logic [ECC_WIDTH-1:0] COL = ECC_WIDTH'(edc_h_column(j, ECC_WIDTH));
        assign col_term[j] = i_data[j] ? COL : '0;
    end

    always_comb begin
        o_gen_ecc = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            o_gen_ecc ^= col_term[j];
        end
        o_syndrome = o_gen_ecc ^ i_ecc;
    end

endmodule

// File: rtl/edc_secded_pipe.sv
// Two-stage SEC-DED read checker: syndrome (S1), correct/flag (S2), error stats.
// Latency: 2 cycles input handshake to o_valid; 1 word/cycle with i_ready high.
// Backpressure: valid/ready both sides, o_ready combinational from i_ready; no skid.
// Ports: i_valid/o_ready/i_data/i_ecc/i_addr in; o_valid/i_ready/o_data/o_addr/
// o_syndrome/o_corrected/o_uncorrectable out; i_cnt_clr, o_cnt_*, o_err_* stats.
import edc_pkg::*;

module edc_secded_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ECC_WIDTH-1:0]  i_ecc,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ECC_WIDTH-1:0]  o_syndrome,
    output logic                  o_corrected,
    output logic                  o_uncorrectable,
    input  logic                  i_cnt_clr,
    output logic [CNT_WIDTH-1:0]  o_cnt_corr,
    output logic [CNT_WIDTH-1:0]  o_cnt_unc,
    output logic [ADDR_WIDTH-1:0] o_err_addr,
    output logic                  o_err_valid
);

    if (DATA_WIDTH < 8 || DATA_WIDTH > EDC_MAX_DATA || ECC_WIDTH > EDC_MAX_ECC) begin : g_bad_width
        $error("edc_secded_pipe: DATA_WIDTH/ECC_WIDTH out of range");
    end
    if (edc_num_columns(ECC_WIDTH) < DATA_WIDTH) begin : g_bad_h
        $error("edc_secded_pipe: too few odd-weight columns for DATA_WIDTH");
    end

    // Stage 1
    logic                  s1_vld_q,  s1_vld_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [ECC_WIDTH-1:0]  s1_syn_q,  s1_syn_d;
    // Stage 2
    logic                  s2_vld_q,  s2_vld_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
    logic [ECC_WIDTH-1:0]  s2_syn_q,  s2_syn_d;
    logic                  s2_corr_q, s2_corr_d;
    logic                  s2_unc_q,  s2_unc_d;
    // Statistics
    logic [CNT_WIDTH-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_WIDTH-1:0]  cnt_unc_q,  cnt_unc_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  err_vld_q,  err_vld_d;

    logic [ECC_WIDTH-1:0]  gen_syn;
    logic [ECC_WIDTH-1:0]  gen_ecc_unused;
    logic [DATA_WIDTH-1:0] data_hit;
    logic                  check_hit;
    logic                  s1_load, s2_load, in_hs, out_hs;

    edc_syndrome_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ECC_WIDTH  (ECC_WIDTH)
    ) u_syn (
        .i_data     (i_data),
        .i_ecc      (i_ecc),
        .o_gen_ecc  (gen_ecc_unused),
        .o_syndrome (gen_syn)
    );

    // Columns are distinct, so at most one data bit can match.
    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_hit
        localparam logic [ECC_WIDTH-1:0] COL = ECC_WIDTH'(edc_h_column(j, ECC_WIDTH));
        assign data_hit[j] = (s1_syn_q == COL);
    end
    // A unit-vector syndrome means a flipped check bit; data needs no fix.
    assign check_hit = $onehot(s1_syn_q);

    assign s2_load = !s2_vld_q || i_ready;
    assign s1_load = !s1_vld_q || s2_load;
    assign in_hs   = i_valid && s1_load;
    assign out_hs  = s2_vld_q && i_ready;

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_data_d  = s1_data_q;
        s1_addr_d  = s1_addr_q;
        s1_syn_d   = s1_syn_q;
        s2_vld_d   = s2_vld_q;
        s2_data_d  = s2_data_q;
        s2_addr_d  = s2_addr_q;
        s2_syn_d   = s2_syn_q;
        s2_corr_d  = s2_corr_q;
        s2_unc_d   = s2_unc_q;
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;
        err_addr_d = err_addr_q;
        err_vld_d  = err_vld_q;

        if (s1_load) begin
            s1_vld_d = i_valid;
            if (in_hs) begin
                s1_data_d = i_data;
                s1_addr_d = i_addr;
                s1_syn_d  = gen_syn;
            end
        end

        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                // data_hit is all-zero for check-bit and uncorrectable cases.
                s2_data_d = s1_data_q ^ data_hit;
                s2_addr_d = s1_addr_q;
                s2_syn_d  = s1_syn_q;
                s2_corr_d = (|data_hit) || check_hit;
                s2_unc_d  = (s1_syn_q != '0) && !((|data_hit) || check_hit);
            end
        end

        // Clear first, then a same-cycle increment/capture lands on top.
        if (i_cnt_clr) begin
            cnt_corr_d = '0;
            cnt_unc_d  = '0;
            err_addr_d = '0;
            err_vld_d  = 1'b0;
        end
        if (out_hs && s2_corr_q && (cnt_corr_d != '1)) begin
            cnt_corr_d = cnt_corr_d + 1'b1;
        end
        if (out_hs && s2_unc_q && (cnt_unc_d != '1)) begin
            cnt_unc_d = cnt_unc_d + 1'b1;
        end
        if (out_hs && (s2_syn_q != '0)) begin
            err_addr_d = s2_addr_q;
            err_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            s1_addr_q  <= '0;
            s1_syn_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_data_q  <= '0;
            s2_addr_q  <= '0;
            s2_syn_q   <= '0;
            s2_corr_q  <= 1'b0;
            s2_unc_q   <= 1'b0;
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
            err_addr_q <= '0;
            err_vld_q  <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_data_q  <= s1_data_d;
            s1_addr_q  <= s1_addr_d;
            s1_syn_q   <= s1_syn_d;
            s2_vld_q   <= s2_vld_d;
            s2_data_q  <= s2_data_d;
            s2_addr_q  <= s2_addr_d;
            s2_syn_q   <= s2_syn_d;
            s2_corr_q  <= s2_corr_d;
            s2_unc_q   <= s2_unc_d;
            cnt_corr_q <= cnt_corr_d;
            cnt_unc_q  <= cnt_unc_d;
            err_addr_q <= err_addr_d;
            err_vld_q  <= err_vld_d;
        end
    end

    assign o_ready         = s1_load;
    assign o_valid         = s2_vld_q;
    assign o_data          = s2_data_q;
    assign o_addr          = s2_addr_q;
    assign o_syndrome      = s2_syn_q;
    assign o_corrected     = s2_corr_q;
    assign o_uncorrectable = s2_unc_q;
    assign o_cnt_corr      = cnt_corr_q;
    assign o_cnt_unc       = cnt_unc_q;
    assign o_err_addr      = err_addr_q;
    assign o_err_valid     = err_vld_q;

endmodule

// File: tb/tb_edc_secded_pipe.sv
// Directed bench for edc_secded_pipe: default instance plus a CNT_WIDTH=2 twin.
// Latency: expects 2-cycle input-to-output with i_ready high.
// Backpressure: drives a 3-cycle i_ready stall during a 4-word stream.
import edc_pkg::*;

module tb_edc_secded_pipe;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_ready, i_cnt_clr;
    logic [31:0] i_data, i_addr;
    logic [7:0]  i_ecc;
    logic        o_ready, o_valid, o_corrected, o_uncorrectable, o_err_valid;
    logic [31:0] o_data, o_addr, o_err_addr;
    logic [7:0]  o_syndrome;
    logic [15:0] o_cnt_corr, o_cnt_unc;

    logic        s_ready, s_valid, s_corrected, s_uncorrectable, s_err_valid;
    logic [31:0] s_data, s_addr, s_err_addr;
    logic [7:0]  s_syndrome;
    logic [1:0]  s_cnt_corr, s_cnt_unc;

    int          n_total = 0;
    int          n_bad   = 0;
    int          exp_cc, exp_cu, exp_sc, exp_su;
    logic        exp_ev;
    logic [31:0] exp_ea;
    logic [7:0]  cols [5] = '{8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13};

    always #5 clk = ~clk;

    edc_secded_pipe dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_ecc(i_ecc), .i_addr(i_addr), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_addr(o_addr), .o_syndrome(o_syndrome),
        .o_corrected(o_corrected), .o_uncorrectable(o_uncorrectable),
        .i_cnt_clr(i_cnt_clr), .o_cnt_corr(o_cnt_corr), .o_cnt_unc(o_cnt_unc),
        .o_err_addr(o_err_addr), .o_err_valid(o_err_valid)
    );

    edc_secded_pipe #(.CNT_WIDTH(2)) dut_sat (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(s_ready),
        .i_data(i_data), .i_ecc(i_ecc), .i_addr(i_addr), .o_valid(s_valid),
        .i_ready(i_ready), .o_data(s_data), .o_addr(s_addr), .o_syndrome(s_syndrome),
        .o_corrected(s_corrected), .o_uncorrectable(s_uncorrectable),
        .i_cnt_clr(i_cnt_clr), .o_cnt_corr(s_cnt_corr), .o_cnt_unc(s_cnt_unc),
        .o_err_addr(s_err_addr), .o_err_valid(s_err_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_cc = 0; exp_cu = 0; exp_sc = 0; exp_su = 0;
        exp_ev = 1'b0; exp_ea = '0;
    endtask

    task automatic model_out(input logic [31:0] addr, input logic [7:0] syn,
                             input bit corr, input bit unc);
        if (corr) begin
            exp_cc++;
            if (exp_sc < 3) exp_sc++;
        end
        if (unc) begin
            exp_cu++;
            if (exp_su < 3) exp_su++;
        end
        if (syn != 8'h00) begin
            exp_ev = 1'b1;
            exp_ea = addr;
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_cnt_corr"}, 64'(o_cnt_corr), 64'(exp_cc));
        check({tag, "_cnt_unc"},  64'(o_cnt_unc),  64'(exp_cu));
        check({tag, "_err_vld"},  64'(o_err_valid), 64'(exp_ev));
        check({tag, "_err_addr"}, 64'(o_err_addr), 64'(exp_ea));
        check({tag, "_sat_corr"}, 64'(s_cnt_corr), 64'(exp_sc));
        check({tag, "_sat_unc"},  64'(s_cnt_unc),  64'(exp_su));
    endtask

    // One word end to end with i_ready high; optional clear on the output cycle.
    task automatic send_word(input string tag, input logic [31:0] data, input logic [7:0] ecc,
                             input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic [7:0] exp_syn, input bit exp_corr, input bit exp_unc,
                             input bit clr_at_out);
        i_data = data; i_ecc = ecc; i_addr = addr; i_valid = 1'b1; i_ready = 1'b1;
        #1;
        check({tag, "_in_rdy"}, 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0; i_data = '0; i_ecc = '0;
        check({tag, "_lat1"}, 64'(o_valid), 64'd0);
        step();
        check({tag, "_vld"},  64'(o_valid), 64'd1);
        check({tag, "_data"}, 64'(o_data), 64'(exp_data));
        check({tag, "_addr"}, 64'(o_addr), 64'(addr));
        check({tag, "_syn"},  64'(o_syndrome), 64'(exp_syn));
        check({tag, "_corr"}, 64'(o_corrected), 64'(exp_corr));
        check({tag, "_unc"},  64'(o_uncorrectable), 64'(exp_unc));
        if (clr_at_out) begin
            i_cnt_clr = 1'b1;
            model_clear();
        end
        model_out(addr, exp_syn, exp_corr, exp_unc);
        step();
        i_cnt_clr = 1'b0;
        check({tag, "_drain"}, 64'(o_valid), 64'd0);
        check_stats(tag);
    endtask

    initial begin
        int acc, rx, rdy_drop_at;
        logic [7:0] ecc_clean;

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
        i_data = '0; i_ecc = '0; i_addr = '0;
        model_clear();
        repeat (3) step();
        check("rst_vld",  64'(o_valid), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_syn",  64'(o_syndrome), 64'd0);
        check("rst_corr", 64'(o_corrected), 64'd0);
        check("rst_unc",  64'(o_uncorrectable), 64'd0);
        check_stats("rst");
        i_rst = 1'b0;
        step();
        check("rst_rdy", 64'(o_ready), 64'd1);

        ecc_clean = 8'(edc_gen_ecc(64'hDEADBEEF, 32, 8));
        send_word("clean",  32'hDEADBEEF, ecc_clean, 32'h100, 32'hDEADBEEF, 8'h00, 0, 0, 0);
        send_word("sbe0",   32'h00000001, 8'h00, 32'h200, 32'h0, 8'h07, 1, 0, 0);
        send_word("chkbit", 32'h00000000, 8'h10, 32'h300, 32'h0, 8'h10, 1, 0, 0);
        send_word("dbe",    32'h00000003, 8'h00, 32'h400, 32'h3, 8'h0C, 0, 1, 0);
        send_word("sbe4",   32'hFFFFFFEF, 8'(edc_gen_ecc(64'hFFFFFFFF, 32, 8)), 32'h480,
                  32'hFFFFFFFF, 8'h13, 1, 0, 0);

        // Clear with no word in flight.
        i_cnt_clr = 1'b1;
        step();
        i_cnt_clr = 1'b0;
        model_clear();
        check_stats("clr");

        // Four single-bit-error words, downstream stalled for the first 3 cycles.
        acc = 0; rx = 0; rdy_drop_at = -1;
        for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
            i_ready = (cyc >= 3);
            i_valid = (acc < 4);
            i_data  = 32'd1 << acc;
            i_ecc   = 8'h00;
            i_addr  = 32'h1000 + 32'(acc);
            #1;
            if (o_valid) begin
                check("bp_addr", 64'(o_addr), 64'(32'h1000 + 32'(rx)));
                check("bp_syn",  64'(o_syndrome), 64'(cols[rx]));
                check("bp_data", 64'(o_data), 64'd0);
            end
            if (!o_ready && rdy_drop_at < 0) rdy_drop_at = acc;
            if (o_valid && i_ready) begin
                model_out(32'h1000 + 32'(rx), cols[rx], 1, 0);
                rx++;
            end
            if (i_valid && o_ready) acc++;
            step();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        check("bp_rx",       64'(rx), 64'd4);
        check("bp_acc",      64'(acc), 64'd4);
        check("bp_rdy_drop", 64'(rdy_drop_at), 64'd2);
        check_stats("bp");

        // Clear coinciding with a corrected word: counter ends at 1.
        send_word("clr_inc", 32'h00000002, 8'h00, 32'h500, 32'h0, 8'h0B, 1, 0, 1);

        // Reset with a word sitting in S1.
        i_data = 32'h00000004; i_ecc = 8'h00; i_addr = 32'h600; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        i_rst = 1'b1;
        step();
        model_clear();
        check("mrst_vld", 64'(o_valid), 64'd0);
        check_stats("mrst");
        i_rst = 1'b0;
        step();
        check("mrst_rdy", 64'(o_ready), 64'd1);
        check("mrst_vld2", 64'(o_valid), 64'd0);
        step();
        check("mrst_vld3", 64'(o_valid), 64'd0);
        check_stats("mrst_end");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
